// File: rtl/mips_cpu_dmem_bridge.sv
// mips_cpu_dmem_bridge
// Bridges the single-cycle CPU data port onto a wait-state memory bus.
// Each CPU request becomes one word-aligned, byte-enabled bus transfer.
// The bridge also formats load data (extension, LWL/LWR merge) and
// replicates store data across the active lanes.
//
// Handshake: a bus strobe (mem_read/mem_write) is the request-valid.
// mem_waitrequest low is the ready. The transfer completes on the rising
// edge where the strobe is high and mem_waitrequest is low. While
// mem_waitrequest is high, the strobe, address, byteenable and writedata
// are held unchanged. On the CPU side, cpu_stall low is the completion
// indication: the CPU commits on the edge that ends the stall-free cycle.
module mips_cpu_dmem_bridge #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [5:0]  cpu_opcode,
  input  logic [31:0] cpu_writedata,
  input  logic [31:0] cpu_rt_old,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  output logic        cpu_fault,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  // Internal access kinds; unknown opcodes collapse onto K_WORD.
  localparam logic [2:0] K_BYTE_S = 3'd0;
  localparam logic [2:0] K_BYTE_U = 3'd1;
  localparam logic [2:0] K_HALF_S = 3'd2;
  localparam logic [2:0] K_HALF_U = 3'd3;
  localparam logic [2:0] K_WORD   = 3'd4;
  localparam logic [2:0] K_LWL    = 3'd5;
  localparam logic [2:0] K_LWR    = 3'd6;

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [2:0]  kind_q;
  logic        write_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] rt_old_q;
  logic [15:0] wait_cnt;
  logic [31:0] rdata_q;

  logic [1:0]  req_a;
  logic [2:0]  req_kind;
  logic        req_is_byte;
  logic        req_is_half;
  logic        req_misalign;
  logic [3:0]  req_be;
  logic [31:0] req_wd;

  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [31:0] shifted;
  logic [31:0] load_result;

  assign req_a = cpu_address[1:0];

  // Decode the opcode into an access kind, split by transfer direction.
  always_comb begin
    req_kind = K_WORD;
    if (cpu_write) begin
      case (cpu_opcode)
        OP_SB:   req_kind = K_BYTE_U;
        OP_SH:   req_kind = K_HALF_U;
        default: req_kind = K_WORD;
      endcase
    end else begin
      case (cpu_opcode)
        OP_LB:   req_kind = K_BYTE_S;
        OP_LBU:  req_kind = K_BYTE_U;
        OP_LH:   req_kind = K_HALF_S;
        OP_LHU:  req_kind = K_HALF_U;
        OP_LWL:  req_kind = K_LWL;
        OP_LWR:  req_kind = K_LWR;
        default: req_kind = K_WORD;
      endcase
    end
  end

  assign req_is_byte  = (req_kind == K_BYTE_S) || (req_kind == K_BYTE_U);
  assign req_is_half  = (req_kind == K_HALF_S) || (req_kind == K_HALF_U);
  assign req_misalign = (req_is_half && req_a[0]) ||
                        ((req_kind == K_WORD) && (req_a != 2'b00));

  // Byte lanes and lane-replicated store data for the incoming request.
  always_comb begin
    req_be = 4'b1111;
    req_wd = cpu_writedata;
    if (req_is_byte) begin
      req_be = 4'b0001 << req_a;
      req_wd = {4{cpu_writedata[7:0]}};
    end else if (req_is_half) begin
      req_be = req_a[1] ? 4'b1100 : 4'b0011;
      req_wd = {2{cpu_writedata[15:0]}};
    end
  end

  // Load formatting from the bus word and the latched request.
  // 8*(3-a) equals {~a, 3'b000} for a two-bit a.
  assign sh_r    = {addr_q[1:0], 3'b000};
  assign sh_l    = {~addr_q[1:0], 3'b000};
  assign shifted = mem_readdata >> sh_r;

  // Select the extension or merge that matches the latched load kind.
  always_comb begin
    load_result = mem_readdata;
    case (kind_q)
      K_BYTE_S: load_result = {{24{shifted[7]}}, shifted[7:0]};
      K_BYTE_U: load_result = {24'h0, shifted[7:0]};
      K_HALF_S: load_result = {{16{shifted[15]}}, shifted[15:0]};
      K_HALF_U: load_result = {16'h0, shifted[15:0]};
      K_LWL:    load_result = (mem_readdata << sh_l) |
                              (rt_old_q & ((32'd1 << sh_l) - 32'd1));
      K_LWR:    load_result = shifted |
                              (rt_old_q & ~(32'hFFFF_FFFF >> sh_r));
      default:  load_result = mem_readdata;
    endcase
  end

  // Request sequencing: latch in IDLE, run the bus transfer, report, or trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr_q   <= 32'h0;
      kind_q   <= K_BYTE_S;
      write_q  <= 1'b0;
      be_q     <= 4'h0;
      wd_q     <= 32'h0;
      rt_old_q <= 32'h0;
      wait_cnt <= 16'h0;
      rdata_q  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_read || cpu_write) begin
            if ((cpu_read && cpu_write) || req_misalign) begin
              state <= ST_FAULT;
            end else begin
              addr_q   <= cpu_address;
              kind_q   <= req_kind;
              write_q  <= cpu_write;
              be_q     <= req_be;
              wd_q     <= req_wd;
              rt_old_q <= cpu_rt_old;
              wait_cnt <= 16'h0;
              state    <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_waitrequest) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt == WAIT_LAST) begin
              state <= ST_FAULT;
            end
          end else begin
            if (!write_q) begin
              rdata_q <= load_result;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_byteenable = be_q;
  assign mem_writedata  = wd_q;
  assign mem_read       = (state == ST_ACCESS) && !write_q;
  assign mem_write      = (state == ST_ACCESS) && write_q;
  assign cpu_readdata   = rdata_q;
  assign cpu_fault      = (state == ST_FAULT);
  // The IDLE term is combinational, so it is masked while reset is held.
  assign cpu_stall      = (state == ST_ACCESS) || (state == ST_FAULT) ||
                          ((state == ST_IDLE) && (cpu_read || cpu_write) && !reset);

endmodule

// File: tb/tb_mips_cpu_dmem_bridge.sv
// Testbench for mips_cpu_dmem_bridge: directed scenarios plus randomized
// loads/stores against a byte-level reference model, with a scoreboard
// monitor checking every bus strobe cycle and every completion cycle.
module tb_mips_cpu_dmem_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [5:0]  cpu_opcode;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_rt_old;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic        cpu_fault;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  int total = 0;
  int bad   = 0;

  // Bus expectation: {is_write, word address, byteenable, writedata}.
  logic [68:0] bus_q[$];
  // Expected cpu_readdata in the completion cycle.
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  bit          done_pending;

  mips_cpu_dmem_bridge #(.MAX_WAIT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_address     (cpu_address),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_opcode      (cpu_opcode),
    .cpu_writedata   (cpu_writedata),
    .cpu_rt_old      (cpu_rt_old),
    .cpu_readdata    (cpu_readdata),
    .cpu_stall       (cpu_stall),
    .cpu_fault       (cpu_fault),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Asserts reset wherever the caller is, checks all outputs drop at once.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_readdata", cpu_readdata, 32'h0);
    check("rst_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_fault", {31'h0, cpu_fault}, 32'h0);
    check("rst_address", mem_address, 32'h0);
    check("rst_read", {31'h0, mem_read}, 32'h0);
    check("rst_write", {31'h0, mem_write}, 32'h0);
    check("rst_be", {28'h0, mem_byteenable}, 32'h0);
    check("rst_wdata", mem_writedata, 32'h0);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    mem_waitrequest = 1'b0;
    bus_q.delete();
    exp_q.delete();
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int access_size(input logic [5:0] op, input bit w);
    if (w) return (op == 6'h28) ? 1 : (op == 6'h29) ? 2 : 4;
    if (op == 6'h20 || op == 6'h24) return 1;
    if (op == 6'h21 || op == 6'h25) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input int size, input int a);
    logic [3:0] be;
    int base;
    base = (size == 4) ? 0 : a;
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + size);
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input int size, input logic [31:0] rt);
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) begin
      if (size == 1)      wd[8*i +: 8] = rt[7:0];
      else if (size == 2) wd[8*i +: 8] = rt[8*(i%2) +: 8];
      else                wd[8*i +: 8] = rt[8*i +: 8];
    end
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input int a,
                                              input logic [31:0] m, input logic [31:0] rt_old);
    logic [7:0]  mb [4];
    logic [7:0]  rb [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      mb[i] = m[8*i +: 8];
      rb[i] = rt_old[8*i +: 8];
    end
    case (op)
      6'h20: r = {{24{mb[a][7]}}, mb[a]};
      6'h24: r = {24'h0, mb[a]};
      6'h21: r = {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
      6'h25: r = {16'h0, mb[a+1], mb[a]};
      6'h22: for (int i = 0; i < 4; i++) r[8*i +: 8] = (i >= 3 - a) ? mb[i - (3 - a)] : rb[i];
      6'h26: for (int i = 0; i < 4; i++) r[8*i +: 8] = (i <= 3 - a) ? mb[i + a] : rb[i];
      default: r = m;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [68:0] e;
    if (reset) begin
      done_pending = 1'b0;
    end else if (mem_read || mem_write) begin
      if (bus_q.size() == 0) begin
        check("unexpected_strobe", {30'h0, mem_write, mem_read}, 32'h0);
      end else begin
        e = bus_q[0];
        check("bus_dir", {31'h0, mem_write}, {31'h0, e[68]});
        check("bus_read", {31'h0, mem_read}, {31'h0, !e[68]});
        check("bus_addr", mem_address, e[67:36]);
        check("bus_be", {28'h0, mem_byteenable}, {28'h0, e[35:32]});
        if (e[68]) check("bus_wdata", mem_writedata, e[31:0]);
        check("access_stall", {31'h0, cpu_stall}, 32'h1);
        if (!mem_waitrequest) begin
          void'(bus_q.pop_front());
          done_pending = 1'b1;
        end
      end
    end else if (done_pending) begin
      done_pending = 1'b0;
      check("done_stall", {31'h0, cpu_stall}, 32'h0);
      if (exp_q.size() == 0) check("done_unexpected", cpu_readdata, 32'hx);
      else check("done_readdata", cpu_readdata, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input bit w, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rt_old,
                           input logic [31:0] m, input int waits);
    int size;
    int a;
    logic [31:0] rd;
    size = access_size(op, w);
    a = int'(addr[1:0]);
    rd = w ? last_rd : model_load(op, a, m, rt_old);
    last_rd = rd;
    bus_q.push_back({w, addr[31:2], 2'b00, model_be(size, a), model_wd(size, rt)});
    exp_q.push_back(rd);
    @(posedge clk);
    #1;
    cpu_read = !w;
    cpu_write = w;
    cpu_opcode = op;
    cpu_address = addr;
    cpu_writedata = rt;
    cpu_rt_old = rt_old;
    mem_readdata = $urandom;
    mem_waitrequest = 1'b0;
    @(negedge clk);
    check("idle_req_stall", {31'h0, cpu_stall}, 32'h1);
    for (int j = 1; j <= waits + 1; j++) begin
      @(posedge clk);
      #1;
      mem_waitrequest = (j <= waits);
      mem_readdata = (j <= waits) ? $urandom : m;
    end
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    mem_waitrequest = 1'b0;
  endtask

  task automatic do_fault(input bit rd, input bit wr, input logic [5:0] op, input logic [31:0] addr);
    @(posedge clk);
    #1;
    cpu_read = rd;
    cpu_write = wr;
    cpu_opcode = op;
    cpu_address = addr;
    @(negedge clk);
    check("fault_idle_stall", {31'h0, cpu_stall}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fault_flag", {31'h0, cpu_fault}, 32'h1);
      check("fault_stall", {31'h0, cpu_stall}, 32'h1);
      check("fault_no_strobe", {30'h0, mem_write, mem_read}, 32'h0);
    end
    #2;
    apply_reset();
  endtask

  task automatic do_timeout(input logic [31:0] addr);
    int cnt;
    cnt = 0;
    bus_q.push_back({1'b0, addr[31:2], 2'b00, 4'b1111, 32'h0});
    @(posedge clk);
    #1;
    cpu_read = 1'b1;
    cpu_opcode = 6'h23;
    cpu_address = addr;
    mem_waitrequest = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (mem_read) cnt++;
      if (cpu_fault) break;
    end
    check("timeout_strobe_cycles", cnt, 32'd4);
    check("timeout_fault", {31'h0, cpu_fault}, 32'h1);
    @(negedge clk);
    check("timeout_no_strobe", {30'h0, mem_write, mem_read}, 32'h0);
    check("timeout_stall", {31'h0, cpu_stall}, 32'h1);
    #2;
    apply_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] rd_ops [10];
    logic [5:0] wr_ops [5];
    rd_ops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00, 6'h3F, 6'h2F};
    wr_ops = '{6'h28, 6'h29, 6'h2B, 6'h2A, 6'h3F};
    reset = 1'b0;
    cpu_address = 32'h0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_opcode = 6'h0;
    cpu_writedata = 32'h0;
    cpu_rt_old = 32'h0;
    mem_readdata = 32'h0;
    mem_waitrequest = 1'b0;
    done_pending = 1'b0;
    last_rd = 32'h0;
    #2;
    apply_reset();

    // Directed scenarios.
    do_access(1'b0, 6'h23, 32'h0000_0100, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
    do_access(1'b0, 6'h20, 32'h0000_0103, 32'h0, 32'h0, 32'h8011_2233, 0);
    do_access(1'b0, 6'h24, 32'h0000_0103, 32'h0, 32'h0, 32'h8011_2233, 1);
    do_access(1'b0, 6'h25, 32'h0000_0102, 32'h0, 32'h0, 32'h8011_2233, 0);
    do_access(1'b1, 6'h29, 32'h0000_0206, 32'h1234_ABCD, 32'h0, 32'h0, 3);
    do_access(1'b0, 6'h22, 32'h0000_0301, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0);
    do_access(1'b0, 6'h26, 32'h0000_0301, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 2);
    do_access(1'b1, 6'h28, 32'h0000_0402, 32'h0000_00A5, 32'h0, 32'h0, 0);

    // Randomized loads and stores.
    for (int n = 0; n < 120; n++) begin
      bit w;
      logic [5:0] op;
      logic [31:0] addr;
      int size;
      w = 1'($urandom_range(0, 1));
      op = w ? wr_ops[$urandom_range(0, 4)] : rd_ops[$urandom_range(0, 9)];
      addr = $urandom;
      size = access_size(op, w);
      if (size == 2) addr[0] = 1'b0;
      if (size == 4 && !(!w && (op == 6'h22 || op == 6'h26))) addr[1:0] = 2'b00;
      do_access(w, op, addr, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    // Faults: timeout, misaligned word/half, conflicting request.
    do_timeout(32'h0000_0500);
    do_fault(1'b1, 1'b0, 6'h23, 32'h0000_0102);
    do_fault(1'b0, 1'b1, 6'h29, 32'h0000_0201);
    do_fault(1'b1, 1'b1, 6'h2B, 32'h0000_0400);

    // Reset in the middle of a waiting read, then a clean read.
    bus_q.push_back({1'b0, 30'h0000_00C0, 2'b00, 4'b1111, 32'h0});
    @(posedge clk);
    #1;
    cpu_read = 1'b1;
    cpu_opcode = 6'h23;
    cpu_address = 32'h0000_0300;
    mem_waitrequest = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("pre_reset_strobe", {31'h0, mem_read}, 32'h1);
    #2;
    apply_reset();
    do_access(1'b0, 6'h23, 32'h0000_0600, 32'h0, 32'h0, 32'h0BAD_F00D, 1);
    repeat (2) @(posedge clk);
    check("queue_drained", bus_q.size() + exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
